// File: rtl/clkgate_seq_pkg.sv
// rtl/clkgate_seq_pkg.sv - shared state encoding and timer width for clkgate_seq
package clkgate_seq_pkg;

  localparam int TMR_W = 8;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/clkgate_seq_tmr.sv
// rtl/clkgate_seq_tmr.sv - loadable down-counter that parks at zero
module clkgate_seq_tmr
  import clkgate_seq_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [TMR_W-1:0] VAL,
  output logic             ZERO
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (LOAD) begin
      r_cnt <= VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign ZERO = (r_cnt == '0);

endmodule

// File: rtl/clkgate_seq.sv
// rtl/clkgate_seq.sv - clock-gate enable sequencer: OFF/WAKE/ON/HOLD with settle and idle timers
module clkgate_seq
  import clkgate_seq_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WAKE_CYC = 4,
  parameter int IDLE_CYC = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  input  logic            TEST_EN,
  output logic            EN,
  output logic [NREQ-1:0] ACK,
  output logic            BUSY,
  output logic [7:0]      WAKE_CNT
);

  localparam logic [TMR_W-1:0] WAKE_LD = TMR_W'(WAKE_CYC - 1);
  localparam logic [TMR_W-1:0] IDLE_LD = TMR_W'(IDLE_CYC - 1);

  state_t           r_state;
  logic             r_busy;
  logic             r_on;
  logic [7:0]       r_wake_cnt;
  logic             w_any_req;
  logic             w_tmr_zero;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;

  assign w_any_req  = |REQ;
  assign w_tmr_load = ((r_state == ST_OFF) && w_any_req) || ((r_state == ST_ON) && !w_any_req);
  assign w_tmr_val  = (r_state == ST_OFF) ? WAKE_LD : IDLE_LD;

  clkgate_seq_tmr u_tmr (
    .CLK  (CLK),
    .RST  (RST),
    .LOAD (w_tmr_load),
    .VAL  (w_tmr_val),
    .ZERO (w_tmr_zero)
  );

  // r_busy/r_on are registered state decodes so EN and ACK never see a decode glitch
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_OFF;
      r_busy     <= 1'b0;
      r_on       <= 1'b0;
      r_wake_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (w_any_req) begin
            r_state <= ST_WAKE;
            r_busy  <= 1'b1;
            if (r_wake_cnt != 8'hFF) r_wake_cnt <= r_wake_cnt + 8'd1;
          end
        end
        ST_WAKE: begin
          if (w_tmr_zero) begin
            r_state <= ST_ON;
            r_on    <= 1'b1;
          end
        end
        ST_ON: begin
          if (!w_any_req) begin
            r_state <= ST_HOLD;
            r_on    <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (w_any_req) begin
            r_state <= ST_ON;
            r_on    <= 1'b1;
          end else if (w_tmr_zero) begin
            r_state <= ST_OFF;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_OFF;
          r_busy  <= 1'b0;
          r_on    <= 1'b0;
        end
      endcase
    end
  end

  assign EN       = r_busy | TEST_EN;
  assign BUSY     = r_busy;
  assign ACK      = REQ & {NREQ{r_on}};
  assign WAKE_CNT = r_wake_cnt;

endmodule

// File: tb/tb_clkgate_seq.sv
// tb/tb_clkgate_seq.sv - self-checking bench for clkgate_seq (default and 1/1 timer instances)
module tb_clkgate_seq;

  typedef struct {
    int st;
    int tmr;
    int wcnt;
  } mdl_t;

  typedef struct {
    logic [3:0] req;
    logic       ten;
    logic       en;
    logic [3:0] ack;
    logic       busy;
  } vec_t;

  logic       CLK;
  logic       RST;
  logic [3:0] REQ;
  logic       TEST_EN;
  logic       EN0, EN1, BUSY0, BUSY1;
  logic [3:0] ACK0, ACK1;
  logic [7:0] WCNT0, WCNT1;

  int   n_checks;
  int   n_errors;
  mdl_t m0, m1;
  vec_t tbl[18];

  clkgate_seq #(.NREQ(4), .WAKE_CYC(4), .IDLE_CYC(8)) u_dut0 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .TEST_EN(TEST_EN),
    .EN(EN0), .ACK(ACK0), .BUSY(BUSY0), .WAKE_CNT(WCNT0)
  );

  clkgate_seq #(.NREQ(4), .WAKE_CYC(1), .IDLE_CYC(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .TEST_EN(TEST_EN),
    .EN(EN1), .ACK(ACK1), .BUSY(BUSY1), .WAKE_CNT(WCNT1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One clock edge of the controller, written from the rules rather than the RTL structure
  function automatic mdl_t mstep(mdl_t m, logic [3:0] req, int wc, int ic);
    mdl_t n = m;
    case (m.st)
      0: if (req != 0) begin n.st = 1; n.tmr = wc - 1; if (m.wcnt < 255) n.wcnt = m.wcnt + 1; end
      1: if (m.tmr == 0) n.st = 2; else n.tmr = m.tmr - 1;
      2: if (req == 0) begin n.st = 3; n.tmr = ic - 1; end
      default: if (req != 0) n.st = 2; else if (m.tmr == 0) n.st = 0; else n.tmr = m.tmr - 1;
    endcase
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_models();
    chk("en0",   {31'd0, EN0},   {31'd0, (m0.st != 0) || TEST_EN});
    chk("busy0", {31'd0, BUSY0}, {31'd0, m0.st != 0});
    chk("ack0",  {28'd0, ACK0},  {28'd0, (m0.st == 2) ? REQ : 4'd0});
    chk("wcnt0", {24'd0, WCNT0}, m0.wcnt);
    chk("en1",   {31'd0, EN1},   {31'd0, (m1.st != 0) || TEST_EN});
    chk("busy1", {31'd0, BUSY1}, {31'd0, m1.st != 0});
    chk("ack1",  {28'd0, ACK1},  {28'd0, (m1.st == 2) ? REQ : 4'd0});
    chk("wcnt1", {24'd0, WCNT1}, m1.wcnt);
  endtask

  task automatic mreset();
    m0 = '{0, 0, 0};
    m1 = '{0, 0, 0};
  endtask

  task automatic drive(input logic [3:0] r, input logic t);
    REQ = r;
    TEST_EN = t;
    #1;
    check_models();
  endtask

  task automatic tick();
    @(posedge CLK);
    m0 = mstep(m0, REQ, 4, 8);
    m1 = mstep(m1, REQ, 1, 1);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    mreset();
    #1;
    check_models();
    @(posedge CLK);
    #1;
    check_models();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST = 1'b1;
    REQ = 4'd0;
    TEST_EN = 1'b0;
    mreset();
    @(negedge CLK);

    tbl[0] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0};
    for (int i = 1; i <= 4; i++) tbl[i] = '{4'b0001, 1'b0, 1'b1, 4'b0000, 1'b1};
    tbl[5] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1};
    for (int i = 6; i <= 14; i++) tbl[i] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1};
    tbl[15] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[16] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0};
    tbl[17] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0};

    // wake latency, idle hold-off, test force-enable
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].req, tbl[i].ten);
      chk($sformatf("tbl%0d_en", i),   {31'd0, EN0},   {31'd0, tbl[i].en});
      chk($sformatf("tbl%0d_ack", i),  {28'd0, ACK0},  {28'd0, tbl[i].ack});
      chk($sformatf("tbl%0d_busy", i), {31'd0, BUSY0}, {31'd0, tbl[i].busy});
      tick();
    end
    chk("tbl_wcnt", {24'd0, WCNT0}, 32'd1);

    // request returns exactly on the HOLD timer==0 cycle
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(4'b0001, 1'b0); tick(); end
    for (int i = 0; i < 8; i++) begin drive(4'b0000, 1'b0); tick(); end
    drive(4'b0100, 1'b0);
    chk("hold0_ack", {28'd0, ACK0}, 32'd0);
    chk("hold0_en",  {31'd0, EN0},  32'd1);
    tick();
    drive(4'b0100, 1'b0);
    chk("rehold_ack",  {28'd0, ACK0},  32'b0100);
    chk("rehold_en",   {31'd0, EN0},   32'd1);
    chk("rehold_busy", {31'd0, BUSY0}, 32'd1);
    tick();

    // asynchronous reset in the middle of WAKE, REQ held through it
    do_reset();
    drive(4'b0001, 1'b0); tick();
    drive(4'b0001, 1'b0); tick();
    drive(4'b0001, 1'b0);
    RST = 1'b1;
    mreset();
    #1;
    chk("rst_en",   {31'd0, EN0},   32'd0);
    chk("rst_ack",  {28'd0, ACK0},  32'd0);
    chk("rst_busy", {31'd0, BUSY0}, 32'd0);
    chk("rst_wcnt", {24'd0, WCNT0}, 32'd0);
    TEST_EN = 1'b1;
    #1;
    chk("rst_ten_en", {31'd0, EN0}, 32'd1);
    check_models();
    TEST_EN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    drive(4'b0001, 1'b0);
    chk("post_rst_busy", {31'd0, BUSY0}, 32'd0);
    tick();
    drive(4'b0001, 1'b0);
    chk("post_rst_wake", {31'd0, BUSY0}, 32'd1);
    tick();

    // 300 wake/sleep cycles saturate the wake counter
    do_reset();
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 5; i++) begin drive(4'b0011, 1'b0); tick(); end
      for (int i = 0; i < 10; i++) begin drive(4'b0000, 1'b0); tick(); end
    end
    chk("sat_wcnt0", {24'd0, WCNT0}, 32'd255);
    chk("sat_wcnt1", {24'd0, WCNT1}, 32'd255);

    // random traffic against the reference model
    do_reset();
    begin
      logic [3:0] r;
      logic       t;
      r = 4'd0;
      t = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 5) == 0) r = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
        t = ($urandom_range(0, 9) == 0);
        drive(r, t);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
